rv32imf_apu_dispatcher: RTL and testbench

- Core-side initiator of the APU request/response interface; the FPU wrapper is the responder on the other end.
- Accepts FP ops from decode, registers each op and holds it stable until granted, then tracks outstanding ops in an in-order tag FIFO.
- Retires responses as register-file writebacks.
- Enforces ordering by only mixing ops of the same latency class; multicycle ops (div/sqrt) run alone.

---
 rtl/rv32imf_apu_dispatcher.sv | 170 +++++++++++++++++
 tb/tb_rv32imf_apu_dispatcher.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32imf_apu_dispatcher.sv
// APU request dispatcher: issues FP ops to the FPU wrapper, tracks outstanding tags in order
// and retires responses as register-file writebacks. Optional macro: RV32IMF_APU_DISPATCHER_DEP_CHECK_EN.
module rv32imf_apu_dispatcher #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int WADDR_W         = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [1:0]           lat_i,
  input  logic [WADDR_W-1:0]   waddr_i,
  input  logic [95:0]          operands_i,
  input  logic [5:0]           op_i,
  input  logic [14:0]          flags_i,
  output logic                 stall_o,
  output logic                 apu_req_o,
  input  logic                 apu_gnt_i,
  output logic [95:0]          apu_operands_o,
  output logic [5:0]           apu_op_o,
  output logic [14:0]          apu_flags_o,
  input  logic                 apu_rvalid_i,
  input  logic [31:0]          apu_rdata_i,
  input  logic [4:0]           apu_rflags_i,
  output logic                 wb_valid_o,
  output logic [WADDR_W-1:0]   wb_waddr_o,
  output logic [31:0]          wb_data_o,
  output logic [4:0]           wb_flags_o,
`ifdef RV32IMF_APU_DISPATCHER_DEP_CHECK_EN
  input  logic [3*WADDR_W-1:0] read_regs_i,
  input  logic [2:0]           read_regs_valid_i,
  output logic                 read_dep_o,
`endif
  output logic                 busy_o,
  output logic                 spurious_o
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, REQ} state_e;

  state_e               state_q, state_d;
  logic [1:0]           cls_q;
  logic [WADDR_W-1:0]   payWaddr_q;
  logic [95:0]          payOperands_q;
  logic [5:0]           payOp_q;
  logic [14:0]          payFlags_q;
  logic [WADDR_W-1:0]   fifoMem_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     rdPtr_q, wrPtr_q;
  logic [CNT_W-1:0]     fifoCount_q;
  logic                 wbValid_q, spurious_q;
  logic [WADDR_W-1:0]   wbWaddr_q;
  logic [31:0]          wbData_q;
  logic [4:0]           wbFlags_q;

  logic [CNT_W-1:0]     inflight;
  logic                 depBlock, issueOk, capture, push, pop;

  // A granted op moves from REQ into the FIFO, so this sum is the same before and after the grant.
  assign inflight = fifoCount_q + CNT_W'(state_q == REQ);

`ifdef RV32IMF_APU_DISPATCHER_DEP_CHECK_EN
  always_comb begin
    read_dep_o = 1'b0;
    for (int r = 0; r < 3; r++) begin
      if (read_regs_valid_i[r]) begin
        for (int e = 0; e < MAX_OUTSTANDING; e++) begin
          if (CNT_W'(e) < fifoCount_q &&
              fifoMem_q[rdPtr_q + PTR_W'(e)] == read_regs_i[r*WADDR_W +: WADDR_W])
            read_dep_o = 1'b1;
        end
        if (state_q == REQ && payWaddr_q == read_regs_i[r*WADDR_W +: WADDR_W])
          read_dep_o = 1'b1;
      end
    end
  end
  assign depBlock = read_dep_o;
`else
  assign depBlock = 1'b0;
`endif

  assign issueOk = (inflight < CNT_W'(MAX_OUTSTANDING)) &&
                   (inflight == '0 || (lat_i == cls_q && cls_q != 2'd3)) && !depBlock;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    push    = 1'b0;
    stall_o = enable_i;
    case (state_q)
      IDLE: begin
        if (enable_i && issueOk) begin
          capture = 1'b1;
          state_d = REQ;
          stall_o = 1'b0;
        end
      end
      REQ: begin
        if (apu_gnt_i) begin
          push = 1'b1;
          if (enable_i && issueOk) begin
            capture = 1'b1;
            stall_o = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A response arriving while the FIFO is empty may still retire the op being granted this cycle.
  assign pop = apu_rvalid_i && (fifoCount_q != '0 || push);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cls_q         <= 2'd0;
      payWaddr_q    <= '0;
      payOperands_q <= '0;
      payOp_q       <= '0;
      payFlags_q    <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifoMem_q[i] <= '0;
      rdPtr_q       <= '0;
      wrPtr_q       <= '0;
      fifoCount_q   <= '0;
      wbValid_q     <= 1'b0;
      wbWaddr_q     <= '0;
      wbData_q      <= '0;
      wbFlags_q     <= '0;
      spurious_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wbValid_q <= pop;
      if (capture) begin
        cls_q         <= lat_i;
        payWaddr_q    <= waddr_i;
        payOperands_q <= operands_i;
        payOp_q       <= op_i;
        payFlags_q    <= flags_i;
      end
      if (push && !(pop && fifoCount_q == '0)) begin
        fifoMem_q[wrPtr_q] <= payWaddr_q;
        wrPtr_q            <= wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
        wbWaddr_q <= (fifoCount_q == '0) ? payWaddr_q : fifoMem_q[rdPtr_q];
        wbData_q  <= apu_rdata_i;
        wbFlags_q <= apu_rflags_i;
        if (fifoCount_q != '0) rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      if (push && !pop)      fifoCount_q <= fifoCount_q + CNT_W'(1);
      else if (pop && !push) fifoCount_q <= fifoCount_q - CNT_W'(1);
      if (apu_rvalid_i && !pop) spurious_q <= 1'b1;
    end
  end

  assign apu_req_o      = (state_q == REQ);
  assign apu_operands_o = payOperands_q;
  assign apu_op_o       = payOp_q;
  assign apu_flags_o    = payFlags_q;
  assign wb_valid_o     = wbValid_q;
  assign wb_waddr_o     = wbWaddr_q;
  assign wb_data_o      = wbData_q;
  assign wb_flags_o     = wbFlags_q;
  assign busy_o         = (state_q == REQ) || (fifoCount_q != '0);
  assign spurious_o     = spurious_q;

endmodule

// File: tb/tb_rv32imf_apu_dispatcher.sv
// Scoreboard bench for rv32imf_apu_dispatcher: directed issue/grant/response sequences,
// writebacks checked by an independent monitor against a queue of expected results.
module tb_rv32imf_apu_dispatcher;

  logic        clk = 1'b0;
  logic        rst, en, gnt, rvalid;
  logic [1:0]  lat;
  logic [4:0]  waddr, rflags;
  logic [95:0] operands;
  logic [5:0]  op;
  logic [14:0] flags;
  logic [31:0] rdata;
  logic        stall, req, wbValid, busy, spurious;
  logic [95:0] apuOperands;
  logic [5:0]  apuOp;
  logic [14:0] apuFlags;
  logic [4:0]  wbWaddr, wbFlags;
  logic [31:0] wbData;
`ifdef RV32IMF_APU_DISPATCHER_DEP_CHECK_EN
  logic [14:0] readRegs;
  logic [2:0]  readRegsValid;
  logic        readDep;
`endif

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] data;
    logic [4:0]  flags;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   errCount = 0;
  int   checkCount = 0;
  logic [31:0] b2bData [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rv32imf_apu_dispatcher #(.MAX_OUTSTANDING(4), .WADDR_W(5)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .lat_i(lat), .waddr_i(waddr),
    .operands_i(operands), .op_i(op), .flags_i(flags), .stall_o(stall),
    .apu_req_o(req), .apu_gnt_i(gnt), .apu_operands_o(apuOperands),
    .apu_op_o(apuOp), .apu_flags_o(apuFlags), .apu_rvalid_i(rvalid),
    .apu_rdata_i(rdata), .apu_rflags_i(rflags), .wb_valid_o(wbValid),
    .wb_waddr_o(wbWaddr), .wb_data_o(wbData), .wb_flags_o(wbFlags),
`ifdef RV32IMF_APU_DISPATCHER_DEP_CHECK_EN
    .read_regs_i(readRegs), .read_regs_valid_i(readRegsValid), .read_dep_o(readDep),
`endif
    .busy_o(busy), .spurious_o(spurious)
  );

  // Compare one value and log a failure line.
  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle response; when a writeback is expected it is queued for the monitor.
  task automatic applyStimulus(input logic [31:0] d, input logic [4:0] f,
                               input logic [4:0] tag, input bit expectWb);
    exp_t e;
    if (expectWb) begin
      e.waddr = tag; e.data = d; e.flags = f; e.due = cyc + 1;
      sbq.push_back(e);
    end
    rvalid = 1'b1; rdata = d; rflags = f;
    step();
    rvalid = 1'b0;
  endtask

  // Monitor: every writeback pulse must match the oldest queued expectation one cycle after rvalid.
  always @(negedge clk) begin
    if (!rst && wbValid) begin
      if (sbq.size() == 0) begin
        checkCount++;
        errCount++;
        $display("[TB] FAIL unexpected writeback: waddr %0d data %0h, none expected", wbWaddr, wbData);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checkOutput("wb_waddr", 96'(wbWaddr), 96'(e.waddr));
        checkOutput("wb_data", 96'(wbData), 96'(e.data));
        checkOutput("wb_flags", 96'(wbFlags), 96'(e.flags));
        checkOutput("wb_latency", 96'(cyc), 96'(e.due));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; gnt = 1'b0; rvalid = 1'b0; lat = 2'd0; waddr = '0;
    rflags = '0; operands = '0; op = '0; flags = '0; rdata = '0;
`ifdef RV32IMF_APU_DISPATCHER_DEP_CHECK_EN
    readRegs = '0; readRegsValid = '0;
`endif
    step(); step();
    rst = 1'b0;
    #1;
    checkOutput("reset req", 96'(req), 96'd0);
    checkOutput("reset busy", 96'(busy), 96'd0);
    checkOutput("reset wb_valid", 96'(wbValid), 96'd0);

    $display("[TB] reset during ungranted request");
    en = 1'b1; lat = 2'd0; waddr = 5'd3;
    step();
    en = 1'b0; #1;
    checkOutput("req before reset", 96'(req), 96'd1);
    rst = 1'b1; step(); step(); rst = 1'b0; #1;
    checkOutput("post-reset req", 96'(req), 96'd0);
    checkOutput("post-reset busy", 96'(busy), 96'd0);
    checkOutput("post-reset stall", 96'(stall), 96'd0);
    checkOutput("post-reset spurious", 96'(spurious), 96'd0);

    $display("[TB] grant stall");
    step();
    en = 1'b1; lat = 2'd0; waddr = 5'd7; op = 6'h00;
    operands = 96'h0000_0001_0000_0002_0000_0003; flags = 15'h1234;
    step();
    waddr = 5'd8; op = 6'h05; operands = 96'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF; flags = 15'h0F0F;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall req", 96'(req), 96'd1);
      checkOutput("stall operands", apuOperands, 96'h0000_0001_0000_0002_0000_0003);
      checkOutput("stall op", 96'(apuOp), 96'h00);
      checkOutput("stall flags", 96'(apuFlags), 96'h1234);
      checkOutput("second op stalled", 96'(stall), 96'd1);
      if (i < 2) step();
    end
    en = 1'b0; gnt = 1'b1;
    step();
    gnt = 1'b0; #1;
    checkOutput("granted req drop", 96'(req), 96'd0);
    checkOutput("one outstanding busy", 96'(busy), 96'd1);
    applyStimulus(32'h1111_1111, 5'h01, 5'd7, 1'b1);
    #1;
    checkOutput("drained busy", 96'(busy), 96'd0);

    $display("[TB] back-to-back issue");
    gnt = 1'b1; en = 1'b1; lat = 2'd0;
    for (int i = 0; i < 4; i++) begin
      waddr = 5'(10 + i); operands = 96'(i + 1);
      #1;
      checkOutput("b2b accept", 96'(stall), 96'd0);
      step();
      checkOutput("b2b req", 96'(req), 96'd1);
    end
    waddr = 5'd14; #1;
    checkOutput("fifth op stalls", 96'(stall), 96'd1);
    step(); #1;
    checkOutput("full still stalls", 96'(stall), 96'd1);
    checkOutput("full req low", 96'(req), 96'd0);
    en = 1'b0; gnt = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(b2bData[i], 5'(i), 5'(10 + i), 1'b1);
    #1;
    checkOutput("b2b drained", 96'(busy), 96'd0);

    $display("[TB] latency class mixing");
    gnt = 1'b1; en = 1'b1; lat = 2'd3; waddr = 5'd20;
    step();
    lat = 2'd0; waddr = 5'd21; #1;
    checkOutput("mix stall REQ", 96'(stall), 96'd1);
    step(); #1;
    checkOutput("mix stall 1", 96'(stall), 96'd1);
    step(); #1;
    checkOutput("mix stall 2", 96'(stall), 96'd1);
    applyStimulus(32'h4049_0FDB, 5'h02, 5'd20, 1'b1);
    #1;
    checkOutput("mix released", 96'(stall), 96'd0);
    step(); #1;
    checkOutput("mix issued req", 96'(req), 96'd1);
    en = 1'b0;
    step();
    gnt = 1'b0;
    applyStimulus(32'h3F00_0000, 5'h00, 5'd21, 1'b1);

    $display("[TB] simultaneous push and pop");
    gnt = 1'b1; en = 1'b1; lat = 2'd1;
    for (int i = 0; i < 4; i++) begin
      waddr = 5'(24 + i);
      step();
    end
    en = 1'b0;
    applyStimulus(32'hC000_0000, 5'h04, 5'd24, 1'b1);
    gnt = 1'b0;
    en = 1'b1; lat = 2'd1; waddr = 5'd28; #1;
    checkOutput("three outstanding accept", 96'(stall), 96'd0);
    checkOutput("three outstanding busy", 96'(busy), 96'd1);
    en = 1'b0;
    for (int i = 1; i < 4; i++) applyStimulus(32'(i * 7), 5'(i), 5'(24 + i), 1'b1);
    #1;
    checkOutput("sim drained", 96'(busy), 96'd0);

    $display("[TB] spurious response");
    applyStimulus(32'hDEAD_BEEF, 5'h1F, 5'd0, 1'b0);
    checkOutput("spurious no wb", 96'(wbValid), 96'd0);
    checkOutput("spurious set", 96'(spurious), 96'd1);
    step(); step();
    checkOutput("spurious sticky", 96'(spurious), 96'd1);
    rst = 1'b1; step(); rst = 1'b0; #1;
    checkOutput("spurious cleared", 96'(spurious), 96'd0);

`ifdef RV32IMF_APU_DISPATCHER_DEP_CHECK_EN
    $display("[TB] read dependency");
    gnt = 1'b1; en = 1'b1; lat = 2'd0; waddr = 5'd5;
    step();
    en = 1'b0;
    step();
    gnt = 1'b0;
    readRegs = {5'd0, 5'd5, 5'd0}; readRegsValid = 3'b010;
    en = 1'b1; waddr = 5'd6; #1;
    checkOutput("read_dep set", 96'(readDep), 96'd1);
    checkOutput("dep stall", 96'(stall), 96'd1);
    readRegsValid = 3'b000; #1;
    checkOutput("read_dep clear", 96'(readDep), 96'd0);
    checkOutput("no dep accept", 96'(stall), 96'd0);
    en = 1'b0;
    applyStimulus(32'h0000_0005, 5'h00, 5'd5, 1'b1);
`endif

    step(); step(); step();
    checkOutput("scoreboard empty", 96'(sbq.size()), 96'd0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
